// File: rtl/calc_pipe_reg.sv
// ---------------------------------------------------------------------------
// calc_pipe_reg
//   Elastic register pipeline of DEPTH stages. Each stage holds one word and
//   one valid bit. A stage advances whenever it is empty or the stage after it
//   is advancing too, so bubbles collapse and back-pressure ripples upstream.
//   The output is driven directly from the last stage's registers.
//
// Ports
//   clock      : rising-edge clock for all state
//   reset      : asynchronous active-low reset (clears valid, data and Count)
//   Data_in    : upstream data word
//   Valid_in   : Data_in is valid this cycle
//   Ready_out  : the block accepts Data_in this cycle
//   Flush      : synchronous clear of every valid bit (data left untouched)
//   Data_out   : data word of the last stage
//   Valid_out  : Data_out is valid
//   Ready_in   : downstream accepts Data_out this cycle
//   Count      : number of occupied stages, 0..DEPTH
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. Valid never
// depends on ready; Ready_out is combinational from Ready_in, the stage valid
// bits and Flush.
// ---------------------------------------------------------------------------
module calc_pipe_reg #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WORD_LENGTH-1:0]       Data_in,
    input  logic                         Valid_in,
    output logic                         Ready_out,
    input  logic                         Flush,
    output logic [WORD_LENGTH-1:0]       Data_out,
    output logic                         Valid_out,
    input  logic                         Ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       valid_d;
    logic [WORD_LENGTH-1:0] data_q [DEPTH];
    logic [WORD_LENGTH-1:0] data_d [DEPTH];
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;

    logic [DEPTH-1:0]       ready;
    logic [DEPTH-1:0]       prev_valid;
    logic [WORD_LENGTH-1:0] prev_data [DEPTH];
    logic                   in_fire;
    logic                   out_fire;

    // Ready ripples from the output back to the input: a stage can take a new
    // word if it is empty or its own word is moving on this cycle.
    always_comb begin : ready_chain
        logic chain;
        chain = Ready_in;
        ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain    = !valid_q[i] || chain;
            ready[i] = chain;
        end
    end

    assign Ready_out = ready[0] && !Flush;
    assign in_fire   = Valid_in && Ready_out;
    assign out_fire  = valid_q[DEPTH-1] && Ready_in;

    always_comb begin
        prev_valid    = '0;
        prev_valid[0] = in_fire;
        prev_data[0]  = Data_in;
        for (int i = 1; i < DEPTH; i++) begin
            prev_valid[i] = valid_q[i-1];
            prev_data[i]  = data_q[i-1];
        end

        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i]) begin
                valid_d[i] = prev_valid[i];
                // Bubbles move the valid bit only; held data stays put.
                // Flush freezes data so a cleared pipe keeps its last words.
                if (prev_valid[i] && !Flush) begin
                    data_d[i] = prev_data[i];
                end
            end
        end
        if (Flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (Flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + CW'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign Data_out  = data_q[DEPTH-1];
    assign Valid_out = valid_q[DEPTH-1];
    assign Count     = count_q;

endmodule
